// File: rtl/sdspi_host_arbiter.sv
// Round-robin arbiter sharing one sdspihost between the autotest FSM (req 0) and user logic (req 1).
// Owns the host reset and a grant watchdog; define SDSPI_ARB_STATS_EN to enable the grant_cnt counters.
module sdspi_host_arbiter #(
  parameter logic [23:0] WDT_CYCLES      = 24'd10000000,
  parameter logic [7:0]  HOST_RST_CYCLES = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  r_block,
  input  logic [1:0]  r_byte,
  input  logic [1:0]  w_block,
  input  logic [1:0]  w_byte,
  input  logic [63:0] block_addr_flat,
  input  logic [15:0] data_in_flat,
  output logic [1:0]  busy_out,
  input  logic        spi_busy,
  output logic        spi_r_block,
  output logic        spi_r_byte,
  output logic        spi_w_block,
  output logic        spi_w_byte,
  output logic [31:0] spi_block_addr,
  output logic [7:0]  spi_data_in,
  output logic        spi_rst,
  output logic        wdt_fault,
  output logic [31:0] grant_cnt
);

  typedef enum logic [1:0] {HRST, IDLE, OWN, GAP} state_t;

  localparam logic [23:0] RST_LAST = {16'd0, HOST_RST_CYCLES} - 24'd1;
  localparam logic [23:0] WDT_LAST = WDT_CYCLES - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rr_last_q, rr_last_d;
  logic        wdt_fault_q, wdt_fault_d;
  logic [31:0] addr_q;
  logic [7:0]  data_q;
  logic        pick1;
  logic        grant_now;

  // With both requesting, the one that did not own the host last time wins.
  assign pick1     = (req == 2'b11) ? ~rr_last_q : req[1];
  assign grant_now = (state_q == IDLE) && !spi_busy && (|req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HRST;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rr_last_q   <= 1'b1;
      wdt_fault_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      wdt_fault_q <= wdt_fault_d;
      addr_q      <= spi_block_addr;
      data_q      <= spi_data_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    wdt_fault_d = wdt_fault_q;
    case (state_q)
      HRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      IDLE: begin
        if (grant_now) begin
          gnt_d     = pick1 ? 2'b10 : 2'b01;
          rr_last_d = pick1;
          cnt_d     = '0;
          state_d   = OWN;
        end
      end
      OWN: begin
        // The watchdog takes priority over a release in the same cycle.
        if (cnt_q == WDT_LAST) begin
          gnt_d       = '0;
          wdt_fault_d = 1'b1;
          cnt_d       = '0;
          state_d     = HRST;
        end else begin
          cnt_d = cnt_q + 24'd1;
          if (!(|(req & gnt_q)) && !spi_busy) begin
            gnt_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = HRST;
    endcase
  end

  always_comb begin
    spi_r_block = |(r_block & gnt_q);
    spi_r_byte  = |(r_byte  & gnt_q);
    spi_w_block = |(w_block & gnt_q);
    spi_w_byte  = |(w_byte  & gnt_q);
    spi_block_addr = addr_q;
    spi_data_in    = data_q;
    busy_out       = 2'b11;
    if (gnt_q[0]) begin
      spi_block_addr = block_addr_flat[31:0];
      spi_data_in    = data_in_flat[7:0];
      busy_out       = {1'b1, spi_busy};
    end else if (gnt_q[1]) begin
      spi_block_addr = block_addr_flat[63:32];
      spi_data_in    = data_in_flat[15:8];
      busy_out       = {spi_busy, 1'b1};
    end
  end

  assign gnt       = gnt_q;
  assign spi_rst   = (state_q == HRST);
  assign wdt_fault = wdt_fault_q;

`ifdef SDSPI_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Per-requester grant counters, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (grant_now) begin
      if (!pick1 && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (pick1 && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt = {cnt1_q, cnt0_q};
`else
  assign grant_cnt = '0;
`endif

endmodule
